// File: rtl/inc_pipe.sv
// Incrementer stage: d = a + 1, with optional saturation and an overflow flag that travels with d.
// Latency: one cycle from input accept to output valid, when the output register is empty or draining.
// Backpressure: two-entry elastic buffer (output + skid); in_ready is registered, no out_ready->in_ready path.
module inc_pipe #(
    parameter int unsigned DATAWIDTH = 16,
    parameter bit          SATURATE  = 1'b0
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] a,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] d,
    output logic                 ovf
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic                 in_ready_q;
    logic [DATAWIDTH-1:0] d_q;
    logic                 ovf_q;
    logic [DATAWIDTH-1:0] skid_d_q;
    logic                 skid_ovf_q;

    logic                 acc;
    logic                 drn;
    logic                 load_out;
    logic                 load_skid;
    logic                 move_skid;

    logic [DATAWIDTH:0]   sum;
    logic                 res_ovf;
    logic [DATAWIDTH-1:0] res_d;

    assign sum     = {1'b0, a} + {{DATAWIDTH{1'b0}}, 1'b1};
    assign res_ovf = sum[DATAWIDTH];
    assign res_d   = (SATURATE && res_ovf) ? {DATAWIDTH{1'b1}} : sum[DATAWIDTH-1:0];

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign d         = d_q;
    assign ovf       = ovf_q;

    assign acc = in_valid & in_ready_q;
    assign drn = out_valid & out_ready;

    always_comb begin
        state_d   = state_q;
        load_out  = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (acc) begin
                    state_d  = ONE;
                    load_out = 1'b1;
                end
            end
            ONE: begin
                if (acc && drn) begin
                    load_out = 1'b1;
                end else if (acc) begin
                    state_d   = TWO;
                    load_skid = 1'b1;
                end else if (drn) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                // in_ready is low here, so nothing new can arrive alongside the skid move
                if (drn) begin
                    state_d   = ONE;
                    move_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != TWO);
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            d_q        <= '0;
            ovf_q      <= 1'b0;
            skid_d_q   <= '0;
            skid_ovf_q <= 1'b0;
        end else begin
            if (load_out) begin
                d_q   <= res_d;
                ovf_q <= res_ovf;
            end else if (move_skid) begin
                d_q   <= skid_d_q;
                ovf_q <= skid_ovf_q;
            end
            if (load_skid) begin
                skid_d_q   <= res_d;
                skid_ovf_q <= res_ovf;
            end else if (move_skid) begin
                skid_d_q   <= '0;
                skid_ovf_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_inc_pipe.sv
// Directed and randomized bench for inc_pipe; a wrapping and a saturating instance share the same inputs.
module tb_inc_pipe;

    logic        Clk;
    logic        Rst;
    logic        in_valid;
    logic [15:0] a;
    logic        out_ready;
    logic        in_ready,   in_ready_s;
    logic        out_valid,  out_valid_s;
    logic [15:0] d,          d_s;
    logic        ovf,        ovf_s;

    int total;
    int bad;

    inc_pipe #(.DATAWIDTH(16), .SATURATE(1'b0)) dut (
        .Clk(Clk), .Rst(Rst),
        .in_valid(in_valid), .in_ready(in_ready), .a(a),
        .out_valid(out_valid), .out_ready(out_ready), .d(d), .ovf(ovf)
    );

    inc_pipe #(.DATAWIDTH(16), .SATURATE(1'b1)) dut_sat (
        .Clk(Clk), .Rst(Rst),
        .in_valid(in_valid), .in_ready(in_ready_s), .a(a),
        .out_valid(out_valid_s), .out_ready(out_ready), .d(d_s), .ovf(ovf_s)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b0; in_valid = 1'b0; a = '0; out_ready = 1'b0;
        step();
        step();
        total++;
        if ({out_valid, d, ovf, in_ready} !== {1'b0, 16'h0000, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: got v=%b d=%h ovf=%b rdy=%b, want 0 0000 0 0", out_valid, d, ovf, in_ready);
        end
        #2 Rst = 1'b1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_before_edge: got %b want 0", in_ready);
        end
        step();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL ready_after_release: got rdy=%b v=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic();
        in_valid = 1'b1; a = 16'h0005; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        total++;
        if ({out_valid, d, ovf} !== {1'b1, 16'h0006, 1'b0}) begin
            bad++;
            $display("FAIL basic_result: got v=%b d=%h ovf=%b want 1 0006 0", out_valid, d, ovf);
        end
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_single_cycle: got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_overflow();
        out_ready = 1'b1;
        in_valid = 1'b1; a = 16'hFFFF;
        step();
        in_valid = 1'b0;
        total++;
        if ({out_valid, d, ovf} !== {1'b1, 16'h0000, 1'b1}) begin
            bad++;
            $display("FAIL wrap_ffff: got v=%b d=%h ovf=%b want 1 0000 1", out_valid, d, ovf);
        end
        total++;
        if ({out_valid_s, d_s, ovf_s} !== {1'b1, 16'hFFFF, 1'b1}) begin
            bad++;
            $display("FAIL sat_ffff: got v=%b d=%h ovf=%b want 1 ffff 1", out_valid_s, d_s, ovf_s);
        end
        step();
        in_valid = 1'b1; a = 16'hFFFE;
        step();
        in_valid = 1'b0;
        total++;
        if ({out_valid, d, ovf} !== {1'b1, 16'hFFFF, 1'b0}) begin
            bad++;
            $display("FAIL wrap_fffe: got v=%b d=%h ovf=%b want 1 ffff 0", out_valid, d, ovf);
        end
        total++;
        if ({out_valid_s, d_s, ovf_s} !== {1'b1, 16'hFFFF, 1'b0}) begin
            bad++;
            $display("FAIL sat_fffe: got v=%b d=%h ovf=%b want 1 ffff 0", out_valid_s, d_s, ovf_s);
        end
        step();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid = 1'b1; a = 16'd1;
        step();
        a = 16'd2;
        total++;
        if (in_ready !== 1'b1 || d !== 16'd2) begin
            bad++;
            $display("FAIL bp_first: got rdy=%b d=%h want 1 0002", in_ready, d);
        end
        step();
        a = 16'd3;
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || d !== 16'd2) begin
            bad++;
            $display("FAIL bp_full: got rdy=%b v=%b d=%h want 0 1 0002", in_ready, out_valid, d);
        end
        step();
        step();
        total++;
        if (in_ready !== 1'b0 || d !== 16'd2) begin
            bad++;
            $display("FAIL bp_hold: got rdy=%b d=%h want 0 0002", in_ready, d);
        end
        out_ready = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b1 || d !== 16'd3 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_drain2: got v=%b d=%h rdy=%b want 1 0003 1", out_valid, d, in_ready);
        end
        step();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || d !== 16'd4) begin
            bad++;
            $display("FAIL bp_drain3: got v=%b d=%h want 1 0004", out_valid, d);
        end
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_no_dup: got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1; a = 16'(i);
            step();
            total++;
            if (out_valid !== 1'b1 || d !== 16'(i + 1)) begin
                bad++;
                $display("FAIL stream_%0d: got v=%b d=%h want 1 %h", i, out_valid, d, 16'(i + 1));
            end
        end
        in_valid = 1'b0;
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL stream_end: got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_random();
        logic [16:0] expq[$];
        logic [16:0] exp_v;
        int          sent, got, cyc, errs;
        logic        held;
        logic [16:0] held_v;
        logic        acc, drn;
        sent = 0; got = 0; cyc = 0; errs = 0; held = 1'b0; held_v = '0;
        while (got < 1000 && cyc < 20000) begin
            if (held && out_valid && {ovf, d} !== held_v) begin
                errs++;
                if (errs < 5) $display("FAIL rand_stable: got %h want %h", {ovf, d}, held_v);
            end
            in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            a         = 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 15) == 0) a = 16'hFFFF;
            out_ready = ($urandom_range(0, 2) != 0);
            acc = in_valid & in_ready;
            drn = out_valid & out_ready;
            if (drn) begin
                if (expq.size() == 0) begin
                    errs++;
                    if (errs < 5) $display("FAIL rand_extra: got %h want none", {ovf, d});
                end else begin
                    exp_v = expq.pop_front();
                    if ({ovf, d} !== exp_v) begin
                        errs++;
                        if (errs < 5) $display("FAIL rand_data_%0d: got %h want %h", got, {ovf, d}, exp_v);
                    end
                end
                got++;
            end
            if (acc) begin
                expq.push_back({1'b0, a} + 17'd1);
                sent++;
            end
            held   = out_valid & ~out_ready;
            held_v = {ovf, d};
            step();
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        total++;
        if (errs != 0 || got != 1000 || expq.size() != 0) begin
            bad++;
            $display("FAIL rand_scoreboard: got errs=%0d outputs=%0d left=%0d want 0 1000 0", errs, got, expq.size());
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; a = 16'd10;
        step();
        a = 16'd20;
        step();
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || d !== 16'd11) begin
            bad++;
            $display("FAIL mid_full: got rdy=%b v=%b d=%h want 0 1 000b", in_ready, out_valid, d);
        end
        #2 Rst = 1'b0;
        #1;
        total++;
        if ({out_valid, d, ovf, in_ready} !== {1'b0, 16'h0000, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL mid_async: got v=%b d=%h ovf=%b rdy=%b want 0 0000 0 0", out_valid, d, ovf, in_ready);
        end
        step();
        #2 Rst = 1'b1;
        step();
        out_ready = 1'b1;
        in_valid = 1'b1; a = 16'd30;
        step();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || d !== 16'd31) begin
            bad++;
            $display("FAIL mid_first_after: got v=%b d=%h want 1 001f", out_valid, d);
        end
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_no_reemit: got v=%b d=%h want v=0", out_valid, d);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_overflow();
        test_back_to_back();
        test_stream();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
